bayes_stoch_acc: RTL and testbench

BAYES_STOCH_ACC -- requirements
Module: bayes_stoch_acc

---
 rtl/bayes_stoch_pkg.sv | 15 +
 rtl/stoch_cmp.sv | 12 +
 rtl/bayes_stoch_acc.sv | 119 +++++++++++
 tb/tb_bayes_stoch_acc.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bayes_stoch_pkg.sv
// rtl/bayes_stoch_pkg.sv - shared state type and default sizing for the stochastic Bayesian accumulator
package bayes_stoch_pkg;

  localparam int M_DEFAULT    = 8;
  localparam int NOBS_DEFAULT = 2;
  localparam int NCNT_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/stoch_cmp.sv
// rtl/stoch_cmp.sv - stochastic number generator bit: random word below probability word
module stoch_cmp #(
  parameter int M = 8
) (
  input  logic [M-1:0] i_rnd,
  input  logic [M-1:0] i_lik,
  output logic         o_bit
);

  assign o_bit = (i_rnd < i_lik);

endmodule

// File: rtl/bayes_stoch_acc.sv
// rtl/bayes_stoch_acc.sv - ANDs per-observation stochastic bits and counts posterior ones over a 2**NCNT window
// Optional prior term enabled by defining BAYES_PRIOR_EN.
module bayes_stoch_acc
  import bayes_stoch_pkg::*;
#(
  parameter int M    = M_DEFAULT,
  parameter int NOBS = NOBS_DEFAULT,
  parameter int NCNT = NCNT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [NOBS*M-1:0] rnd,
  input  logic [NOBS*M-1:0] lik,
`ifdef BAYES_PRIOR_EN
  input  logic [M-1:0]      prior,
  input  logic [M-1:0]      rnd_prior,
`endif
  output logic              load_lfsr,
  output logic              inference,
  output logic              busy,
  output logic              done,
  output logic [NCNT:0]     count
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NCNT-1:0] r_cyc;
  logic [NCNT:0]   r_count;
  logic            r_load_lfsr;
  logic            r_inference;
  logic            r_busy;
  logic            r_done;
  logic [NOBS-1:0] w_b;
  logic            w_p;

  for (genvar g = 0; g < NOBS; g++) begin : g_obs
    stoch_cmp #(.M(M)) u_cmp (
      .i_rnd (rnd[g*M +: M]),
      .i_lik (lik[g*M +: M]),
      .o_bit (w_b[g])
    );
  end

`ifdef BAYES_PRIOR_EN
  logic w_b_prior;

  stoch_cmp #(.M(M)) u_cmp_prior (
    .i_rnd (rnd_prior),
    .i_lik (prior),
    .o_bit (w_b_prior)
  );

  assign w_p = (&w_b) & w_b_prior;
`else
  assign w_p = &w_b;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = ST_RUN;
      ST_RUN:  if (&r_cyc) w_state_nxt = ST_DONE;
      ST_DONE: if (start) w_state_nxt = ST_LOAD;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (abort) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // LFSR commands are decoded from the next state so they leave flops directly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_lfsr <= 1'b0;
      r_inference <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_load_lfsr <= (w_state_nxt == ST_LOAD);
      r_inference <= (w_state_nxt == ST_RUN);
      r_busy      <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_RUN);
      r_done      <= (w_state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc   <= '0;
      r_count <= '0;
    end else begin
      if (w_state_nxt == ST_LOAD) begin
        r_cyc <= '0;
      end else if (r_state == ST_RUN) begin
        r_cyc <= r_cyc + 1'b1;
      end
      if (abort || (w_state_nxt == ST_LOAD)) begin
        r_count <= '0;
      end else if ((r_state == ST_RUN) && w_p) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign load_lfsr = r_load_lfsr;
  assign inference = r_inference;
  assign busy      = r_busy;
  assign done      = r_done;
  assign count     = r_count;

endmodule

// File: tb/tb_bayes_stoch_acc.sv
// tb/tb_bayes_stoch_acc.sv - self-checking bench for bayes_stoch_acc (prior term when BAYES_PRIOR_EN is defined)
module tb_bayes_stoch_acc;

  localparam int M    = 8;
  localparam int NOBS = 2;
  localparam int NCNT = 8;
  localparam int WIN  = 1 << NCNT;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [NOBS*M-1:0] rnd;
  logic [NOBS*M-1:0] lik;
  logic              load_lfsr;
  logic              inference;
  logic              busy;
  logic              done;
  logic [NCNT:0]     count;
`ifdef BAYES_PRIOR_EN
  logic [M-1:0]      prior;
  logic [M-1:0]      rnd_prior;
`endif

  always #5 clk = ~clk;

  bayes_stoch_acc #(.M(M), .NOBS(NOBS), .NCNT(NCNT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .rnd       (rnd),
    .lik       (lik),
`ifdef BAYES_PRIOR_EN
    .prior     (prior),
    .rnd_prior (rnd_prior),
`endif
    .load_lfsr (load_lfsr),
    .inference (inference),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  typedef struct {
    int mode;
    int l0;
    int l1;
    int lp;
    int exp;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   s0 [WIN];
  int   s1 [WIN];
  int   sp [WIN];
  int   l0, l1, lp;
  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int flags();
    return {28'd0, load_lfsr, inference, busy, done};
  endfunction

  // Posterior count straight from the definition: windows where every term is true
  function automatic int model();
    int n = 0;
    for (int j = 0; j < WIN; j++)
      if (s0[j] < l0 && s1[j] < l1 && sp[j] < lp) n++;
    return n;
  endfunction

  task automatic fill(input int mode);
    for (int j = 0; j < WIN; j++) begin
      sp[j] = 0;
      case (mode)
        0: begin s0[j] = j; s1[j] = j; end
        1: begin s0[j] = j; s1[j] = 255 - j; end
        3: begin s0[j] = $urandom_range(0, 254); s1[j] = $urandom_range(0, 254); end
        4: begin s0[j] = j; s1[j] = j; sp[j] = j; end
        default: begin s0[j] = $urandom_range(0, 255); s1[j] = $urandom_range(0, 255); end
      endcase
    end
  endtask

  task automatic apply(input int j);
    rnd = {8'(s1[j]), 8'(s0[j])};
`ifdef BAYES_PRIOR_EN
    rnd_prior = 8'(sp[j]);
`endif
  endtask

  task automatic run_window(input string tag, input int keep_start, input int abort_at, input int exp);
    int bad = 0;
    lik = {8'(l1), 8'(l0)};
`ifdef BAYES_PRIOR_EN
    prior = 8'(lp);
`endif
    start = 1'b1;
    tick();
    check({tag, " load flags"}, flags(), 4'b1010);
    check({tag, " load count"}, int'(count), 0);
    if (keep_start == 0) start = 1'b0;
    tick();
    for (int j = 0; j < WIN; j++) begin
      if (j == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check({tag, " abort flags"}, flags(), 0);
        check({tag, " abort count"}, int'(count), 0);
        return;
      end
      apply(j);
      if (!(inference && !load_lfsr && busy && !done)) bad++;
      tick();
    end
    start = 1'b0;
    check({tag, " run protocol"}, bad, 0);
    check({tag, " done flags"}, flags(), 4'b0001);
    check({tag, " count"}, int'(count), exp);
  endtask

  initial begin
    int held;

    vecs[0] = '{0, 128, 255, 255, 128};
    vecs[1] = '{0,   0, 255, 255,   0};
    vecs[2] = '{0, 255, 255, 255, 255};
    vecs[3] = '{0, 100,  50, 255,  50};
    vecs[4] = '{1, 128, 128, 255,   0};
    vecs[5] = '{1, 200, 100, 255,  44};
    vecs[6] = '{3, 255, 255, 255, 256};
    vecs[7] = '{2, 128, 192, 255,  -1};

    rst = 1'b1; start = 1'b1; abort = 1'b0; rnd = '0; lik = '0;
`ifdef BAYES_PRIOR_EN
    prior = '0; rnd_prior = '0;
`endif
    repeat (3) tick();
    check("reset flags", flags(), 0);
    check("reset count", int'(count), 0);
    rst = 1'b0; start = 1'b0;
    tick();
    check("idle after reset", flags(), 0);

    for (int i = 0; i < 8; i++) begin
      fill(vecs[i].mode);
      l0 = vecs[i].l0; l1 = vecs[i].l1; lp = vecs[i].lp;
      run_window($sformatf("vec%0d", i), 0, -1, (vecs[i].exp < 0) ? model() : vecs[i].exp);
    end

    held = int'(count);
    for (int k = 0; k < 5; k++) begin
      rnd = 16'($urandom);
      tick();
    end
    check("done hold flags", flags(), 4'b0001);
    check("done hold count", int'(count), held);

    fill(0); l0 = 128; l1 = 255; lp = 255;
    run_window("restart a", 0, -1, 128);
    run_window("restart b", 0, -1, 128);

    fill(2); l0 = 200; l1 = 90; lp = 255;
    run_window("start held", 1, -1, model());

    run_window("abort", 0, 98, 0);
    repeat (3) tick();
    check("idle after abort", flags(), 0);

    run_window("pre abort-start", 0, -1, model());
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort beats start flags", flags(), 0);
    check("abort beats start count", int'(count), 0);

    fill(0); l0 = 255; l1 = 255; lp = 255;
    lik = {8'(l1), 8'(l0)};
    start = 1'b1; tick(); start = 1'b0; tick();
    for (int j = 0; j < 50; j++) begin apply(j); tick(); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-run reset flags", flags(), 0);
    check("mid-run reset count", int'(count), 0);
    run_window("after reset", 0, -1, 255);

    for (int r = 0; r < 3; r++) begin
      fill(2);
      l0 = $urandom_range(0, 255); l1 = $urandom_range(0, 255); lp = 255;
      run_window($sformatf("rand%0d", r), 0, -1, model());
    end

`ifdef BAYES_PRIOR_EN
    fill(4); l0 = 255; l1 = 255; lp = 64;
    run_window("prior", 0, -1, 64);
    fill(2); l0 = 230; l1 = 210; lp = 150;
    for (int j = 0; j < WIN; j++) sp[j] = $urandom_range(0, 255);
    run_window("prior rand", 0, -1, model());
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
